// File: rtl/lockin_photon_counter_multi.sv
// Multi-channel lock-in photon counter.
// Generates a square-wave light-source drive plus a quadrature reference that
// lags it by 90 degrees. Each PMT channel is synchronised and edge-detected,
// and every photon is binned by reference phase into I/Q add/subtract
// accumulators. Once per integration window the signed I/Q differences, the
// saturating totals and the saturation flags are published with a one-cycle
// valid strobe.
module lockin_photon_counter_multi #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 32,
  parameter int TICK_W = 32
) (
  input  logic                        clock_50_mhz,
  input  logic                        reset,
  input  logic [NUM_CH-1:0]           PMT_in,
  input  logic                        run,
  input  logic [TICK_W-1:0]           quarter_ticks,
  input  logic [TICK_W-1:0]           integration_ticks,
  output logic                        light_source_pin,
  output logic                        quadrature_ref,
  output logic                        result_valid,
  output logic [NUM_CH*(CNT_W+1)-1:0] in_phase_value,
  output logic [NUM_CH*(CNT_W+1)-1:0] quadrature_value,
  output logic [NUM_CH*CNT_W-1:0]     total_count,
  output logic [NUM_CH-1:0]           sat_flag
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Reference generator state
  logic [TICK_W-1:0] quarter_cnt_reg;
  logic [TICK_W-1:0] quarter_len_reg;
  logic              quarter_load_reg;
  logic [1:0]        phase_reg;
  logic              light_reg;
  logic              quad_reg;
  logic [TICK_W-1:0] quarter_eff;
  logic              quarter_wrap;
  logic              ref_i;
  logic              ref_q;

  // Integration window state
  logic [TICK_W-1:0] win_cnt_reg;
  logic [TICK_W-1:0] win_len_reg;
  logic              win_load_reg;
  logic              valid_reg;
  logic [TICK_W-1:0] win_eff;
  logic              dump;

  // Input synchronisers and edge detection
  logic [NUM_CH-1:0] sync1_reg;
  logic [NUM_CH-1:0] sync2_reg;
  logic [NUM_CH-1:0] sync2_d_reg;
  logic [NUM_CH-1:0] photon;

  // The quarter length is taken live on the first cycle of phase 0 and held
  // for the rest of the period, so a mid-period change never shortens a
  // half-cycle. The same load-on-first-cycle scheme is used for the window.
  always_comb begin
    quarter_eff  = quarter_len_reg;
    if (quarter_load_reg) begin
      quarter_eff = (quarter_ticks == '0) ? TICK_W'(1) : quarter_ticks;
    end
    quarter_wrap = (quarter_cnt_reg == quarter_eff - TICK_W'(1));
    ref_i        = ~phase_reg[1];
    ref_q        = phase_reg[0] ^ phase_reg[1];
    win_eff      = win_len_reg;
    if (win_load_reg) begin
      win_eff = (integration_ticks == '0) ? TICK_W'(1) : integration_ticks;
    end
    dump         = run && (win_cnt_reg == win_eff - TICK_W'(1));
  end

  // Quarter counter, phase advance and registered reference outputs
  always_ff @(posedge clock_50_mhz) begin
    if (reset) begin
      quarter_cnt_reg  <= '0;
      quarter_len_reg  <= '0;
      quarter_load_reg <= 1'b1;
      phase_reg        <= 2'd0;
      light_reg        <= 1'b0;
      quad_reg         <= 1'b0;
    end else begin
      light_reg        <= ref_i;
      quad_reg         <= ref_q;
      if (quarter_load_reg) begin
        quarter_len_reg <= quarter_eff;
      end
      quarter_load_reg <= quarter_wrap && (phase_reg == 2'd3);
      if (quarter_wrap) begin
        quarter_cnt_reg <= '0;
        phase_reg       <= phase_reg + 2'd1;
      end else begin
        quarter_cnt_reg <= quarter_cnt_reg + TICK_W'(1);
      end
    end
  end

  // Window timer and result strobe; run low holds the window at its start
  always_ff @(posedge clock_50_mhz) begin
    if (reset) begin
      win_cnt_reg  <= '0;
      win_len_reg  <= '0;
      win_load_reg <= 1'b1;
      valid_reg    <= 1'b0;
    end else begin
      valid_reg    <= dump;
      if (win_load_reg) begin
        win_len_reg <= win_eff;
      end
      win_load_reg <= ~run | dump;
      if (~run | dump) begin
        win_cnt_reg <= '0;
      end else begin
        win_cnt_reg <= win_cnt_reg + TICK_W'(1);
      end
    end
  end

  // Two-flop synchroniser plus one delay stage for rising-edge detection
  always_ff @(posedge clock_50_mhz) begin
    if (reset) begin
      sync1_reg   <= '0;
      sync2_reg   <= '0;
      sync2_d_reg <= '0;
    end else begin
      sync1_reg   <= PMT_in;
      sync2_reg   <= sync1_reg;
      sync2_d_reg <= sync2_reg;
    end
  end

  assign photon = sync2_reg & ~sync2_d_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [CNT_W-1:0] i_add_reg, i_sub_reg, q_add_reg, q_sub_reg;
      logic             sat_win_reg;
      logic [CNT_W:0]   i_val_reg, q_val_reg;
      logic [CNT_W-1:0] total_reg;
      logic             sat_reg;
      logic             hit_i_add, hit_i_sub, hit_q_add, hit_q_sub;
      logic             sat_hit;
      logic [CNT_W:0]   sum;

      // Route this channel's photon into one I bin and one Q bin
      always_comb begin
        hit_i_add = photon[gi] & ref_i;
        hit_i_sub = photon[gi] & ~ref_i;
        hit_q_add = photon[gi] & ref_q;
        hit_q_sub = photon[gi] & ~ref_q;
        sat_hit   = (hit_i_add && (i_add_reg == CNT_MAX)) ||
                    (hit_i_sub && (i_sub_reg == CNT_MAX)) ||
                    (hit_q_add && (q_add_reg == CNT_MAX)) ||
                    (hit_q_sub && (q_sub_reg == CNT_MAX));
        sum       = {1'b0, i_add_reg} + {1'b0, i_sub_reg};
      end

      // Saturating accumulation; on the dump cycle publish results and
      // restart the bins with any photon seen on that same cycle
      always_ff @(posedge clock_50_mhz) begin
        if (reset) begin
          i_add_reg   <= '0;
          i_sub_reg   <= '0;
          q_add_reg   <= '0;
          q_sub_reg   <= '0;
          sat_win_reg <= 1'b0;
          i_val_reg   <= '0;
          q_val_reg   <= '0;
          total_reg   <= '0;
          sat_reg     <= 1'b0;
        end else begin
          if (dump) begin
            i_val_reg <= {1'b0, i_add_reg} - {1'b0, i_sub_reg};
            q_val_reg <= {1'b0, q_add_reg} - {1'b0, q_sub_reg};
            total_reg <= sum[CNT_W] ? CNT_MAX : sum[CNT_W-1:0];
            sat_reg   <= sat_win_reg;
          end
          if (!run) begin
            i_add_reg   <= '0;
            i_sub_reg   <= '0;
            q_add_reg   <= '0;
            q_sub_reg   <= '0;
            sat_win_reg <= 1'b0;
          end else if (dump) begin
            i_add_reg   <= CNT_W'(hit_i_add);
            i_sub_reg   <= CNT_W'(hit_i_sub);
            q_add_reg   <= CNT_W'(hit_q_add);
            q_sub_reg   <= CNT_W'(hit_q_sub);
            sat_win_reg <= 1'b0;
          end else begin
            if (hit_i_add && (i_add_reg != CNT_MAX)) i_add_reg <= i_add_reg + CNT_W'(1);
            if (hit_i_sub && (i_sub_reg != CNT_MAX)) i_sub_reg <= i_sub_reg + CNT_W'(1);
            if (hit_q_add && (q_add_reg != CNT_MAX)) q_add_reg <= q_add_reg + CNT_W'(1);
            if (hit_q_sub && (q_sub_reg != CNT_MAX)) q_sub_reg <= q_sub_reg + CNT_W'(1);
            sat_win_reg <= sat_win_reg | sat_hit;
          end
        end
      end

      assign in_phase_value[gi*(CNT_W+1) +: (CNT_W+1)]   = i_val_reg;
      assign quadrature_value[gi*(CNT_W+1) +: (CNT_W+1)] = q_val_reg;
      assign total_count[gi*CNT_W +: CNT_W]              = total_reg;
      assign sat_flag[gi]                                = sat_reg;
    end
  endgenerate

  assign light_source_pin = light_reg;
  assign quadrature_ref   = quad_reg;
  assign result_valid     = valid_reg;

endmodule
